// File: rtl/busca_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// FSM states, PC increment and RISC-V field positions.
package busca_pkg;

  typedef enum logic [1:0] {
    OCIOSO,
    ESPERA,
    ENTREGA
  } estado_t;

  localparam int PC_INC = 4;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int F3_LSB  = 12;
  localparam int F3_MSB  = 14;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;
  localparam int F7_LSB  = 25;
  localparam int F7_MSB  = 31;

endpackage

// File: rtl/busca_instrucao_contador.sv
// Loadable 4-bit down-counter for the memory wait.
// fim flags the final wait cycle (count == 1).
module contador_espera (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       carga,
  input  logic       decr,
  input  logic [3:0] valor,
  output logic       fim
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt <= 4'd0;
    end else if (carga) begin
      cnt <= valor;
    end else if (decr && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign fim = (cnt == 4'd1);

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch: PC, fixed-latency read, IR and field decode.
// BUSCA_ALINH_CHECK_EN enables the misaligned-target check.
module busca_instrucao
  import busca_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int INSTR_W  = 32,
  parameter int MEM_LAT  = 2,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               escreveInstr,
  input  logic               RWmemoria,
  input  logic               escritaPC,
  input  logic               estadoUla,
  input  logic [PC_W-1:0]    pcAlvo,
  input  logic [INSTR_W-1:0] memDado,
  output logic [PC_W-1:0]    memAddr,
  output logic               memLer,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic [6:0]         opcode,
  output logic [4:0]         rd,
  output logic [2:0]         funct3,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [6:0]         funct7,
  output logic               instrValida,
  output logic               ocupado,
  output logic               erroAlinh
);

  localparam logic [3:0] LAT4 = 4'(MEM_LAT);

  estado_t estado, prox;
  logic aceita;
  logic fim;
  logic [PC_W-1:0] alvo_ef;

  assign aceita = (estado == OCIOSO)
                && escreveInstr && !RWmemoria;

  always_ff @(posedge clk) begin
    if (rst_n) estado <= OCIOSO;
    else       estado <= prox;
  end

  always_comb begin
    prox = estado;
    unique case (estado)
      OCIOSO:  if (aceita) prox = ESPERA;
      ESPERA:  if (fim) prox = ENTREGA;
      ENTREGA: prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
  end

  contador_espera u_cont (
    .clk   (clk),
    .rst_n (rst_n),
    .carga (aceita),
    .decr  (estado == ESPERA),
    .valor (LAT4),
    .fim   (fim)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      memAddr <= '0;
      instr   <= '0;
    end else begin
      if (aceita) memAddr <= pc;
      if (estado == ESPERA && fim) instr <= memDado;
    end
  end

  assign memLer      = (estado == ESPERA);
  assign instrValida = (estado == ENTREGA);
  assign ocupado     = (estado != OCIOSO);

`ifdef BUSCA_ALINH_CHECK_EN
  assign alvo_ef = {pcAlvo[PC_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst_n) begin
      erroAlinh <= 1'b0;
    end else if (escritaPC && !estadoUla
                 && pcAlvo[1:0] != 2'b00) begin
      erroAlinh <= 1'b1;
    end
  end
`else
  assign alvo_ef   = pcAlvo;
  assign erroAlinh = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pc <= PC_W'(RESET_PC);
    end else if (escritaPC) begin
      unique case (1'b1)
        estadoUla:  pc <= pc + PC_W'(PC_INC);
        !estadoUla: pc <= alvo_ef;
      endcase
    end
  end

  assign opcode = instr[OPC_MSB:OPC_LSB];
  assign rd     = instr[RD_MSB:RD_LSB];
  assign funct3 = instr[F3_MSB:F3_LSB];
  assign rs1    = instr[RS1_MSB:RS1_LSB];
  assign rs2    = instr[RS2_MSB:RS2_LSB];
  assign funct7 = instr[F7_MSB:F7_LSB];

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: directed plus random stimulus
// against a cycle-indexed timing model of the fetch.
module tb_busca_instrucao;

  localparam int LAT = 2;
  localparam logic [31:0] RPC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        escreveInstr, RWmemoria;
  logic        escritaPC, estadoUla;
  logic [31:0] pcAlvo, memDado;
  logic [31:0] memAddr, pc, instr;
  logic        memLer, instrValida, ocupado, erroAlinh;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  int total = 0;
  int passou = 0;

  // reference state
  logic [31:0] m_pc, m_instr, m_addr;
  logic        m_err;
  bit          act;
  int          acc;
  int          cyc = 0;

  always #5 clk = ~clk;

  busca_instrucao #(
    .PC_W(32), .INSTR_W(32),
    .MEM_LAT(LAT), .RESET_PC(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .escreveInstr(escreveInstr),
    .RWmemoria(RWmemoria),
    .escritaPC(escritaPC),
    .estadoUla(estadoUla),
    .pcAlvo(pcAlvo), .memDado(memDado),
    .memAddr(memAddr), .memLer(memLer),
    .pc(pc), .instr(instr),
    .opcode(opcode), .rd(rd),
    .funct3(funct3), .rs1(rs1),
    .rs2(rs2), .funct7(funct7),
    .instrValida(instrValida),
    .ocupado(ocupado),
    .erroAlinh(erroAlinh)
  );

  task automatic confere(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] esp);
    total++;
    if (obs === esp) passou++;
    else $display("FAIL %s: got %h expected %h",
                  tag, obs, esp);
  endtask

  task automatic modelo_borda();
    int t;
    bit livre;
    t = cyc;
    if (rst_n) begin
      m_pc = RPC; m_instr = 0; m_addr = 0;
      m_err = 0; act = 0;
    end else begin
      livre = !act || (t >= acc + LAT + 2);
      if (act && t == acc + LAT) m_instr = memDado;
      if (livre && escreveInstr && !RWmemoria) begin
        act = 1; acc = t; m_addr = m_pc;
      end
      if (escritaPC) begin
        if (estadoUla) m_pc = m_pc + 32'd4;
        else begin
`ifdef BUSCA_ALINH_CHECK_EN
          if (pcAlvo[1:0] != 2'b00) m_err = 1;
          m_pc = pcAlvo & ~32'd3;
`else
          m_pc = pcAlvo;
`endif
        end
      end
    end
    cyc++;
  endtask

  task automatic confere_tudo();
    int c;
    c = cyc;
    confere("memLer", 32'(memLer),
            32'(act && c > acc && c <= acc + LAT));
    confere("instrValida", 32'(instrValida),
            32'(act && c == acc + LAT + 1));
    confere("ocupado", 32'(ocupado),
            32'(act && c > acc && c <= acc + LAT + 1));
    confere("pc", pc, m_pc);
    confere("instr", instr, m_instr);
    confere("memAddr", memAddr, m_addr);
    confere("erroAlinh", 32'(erroAlinh), 32'(m_err));
    confere("opcode", 32'(opcode), 32'(m_instr[6:0]));
    confere("rd", 32'(rd), 32'(m_instr[11:7]));
    confere("funct3", 32'(funct3), 32'(m_instr[14:12]));
    confere("rs1", 32'(rs1), 32'(m_instr[19:15]));
    confere("rs2", 32'(rs2), 32'(m_instr[24:20]));
    confere("funct7", 32'(funct7), 32'(m_instr[31:25]));
  endtask

  task automatic ciclo(input logic r, input logic esc,
                       input logic rw, input logic epc,
                       input logic ula,
                       input logic [31:0] alvo,
                       input logic [31:0] dado);
    rst_n = r; escreveInstr = esc; RWmemoria = rw;
    escritaPC = epc; estadoUla = ula;
    pcAlvo = alvo; memDado = dado;
    @(posedge clk);
    modelo_borda();
    @(negedge clk);
    confere_tudo();
  endtask

  task automatic ocioso(input int n,
                        input logic [31:0] dado);
    for (int i = 0; i < n; i++)
      ciclo(0, 0, 0, 0, 0, 0, dado);
  endtask

  initial begin
    act = 0; acc = 0;
    m_pc = RPC; m_instr = 0; m_addr = 0; m_err = 0;
    ciclo(1, 0, 0, 0, 0, 0, 0);
    ciclo(1, 0, 0, 0, 0, 0, 0);
    confere("rst_pc", pc, 32'h0);
    confere("rst_instr", instr, 32'h0);

    // first fetch, fixed data word
    ciclo(0, 1, 0, 0, 0, 0, 32'h00A00093);
    ocioso(LAT, 32'h00A00093);
    confere("f1_instr", instr, 32'h00A00093);
    confere("f1_opcode", 32'(opcode), 32'h13);
    confere("f1_rd", 32'(rd), 32'd1);
    confere("f1_valida", 32'(instrValida), 32'd1);
    ocioso(1, 0);

    // leMem, addPC, espera x3
    for (int k = 0; k < 3; k++) begin
      ciclo(0, 1, 0, 0, 0, 0, $urandom);
      ciclo(0, 0, 0, 1, 1, 0, $urandom);
      ocioso(LAT, $urandom);
      confere("seq_addr", memAddr, 32'(4 * k));
    end
    confere("seq_pc", pc, 32'd12);

    // jump during ESPERA keeps in-flight address
    ciclo(1, 0, 0, 0, 0, 0, 0);
    ciclo(0, 1, 0, 0, 0, 0, $urandom);
    ciclo(0, 0, 0, 1, 0, 32'h100, $urandom);
    confere("jmp_addr", memAddr, 32'h0);
    ocioso(LAT + 1, $urandom);
    ciclo(0, 1, 0, 0, 0, 0, $urandom);
    confere("jmp_next", memAddr, 32'h100);
    ocioso(LAT + 1, $urandom);

    // write request ignored; double request dropped
    ciclo(0, 1, 1, 0, 0, 0, $urandom);
    ciclo(0, 1, 0, 0, 0, 0, $urandom);
    ciclo(0, 1, 0, 0, 0, 0, $urandom);
    ocioso(LAT + 2, $urandom);

    // reset mid-ESPERA
    ciclo(0, 1, 0, 0, 0, 0, $urandom);
    ciclo(1, 0, 0, 0, 0, 0, $urandom);
    confere("rst_memLer", 32'(memLer), 32'd0);
    ocioso(LAT + 1, $urandom);

    // PC wrap
    ciclo(0, 0, 0, 1, 0, 32'hFFFF_FFFC, 0);
    ciclo(0, 0, 0, 1, 1, 0, 0);
    confere("wrap_pc", pc, 32'h0);

    // misaligned target
    ciclo(0, 0, 0, 1, 0, 32'h102, 0);
`ifdef BUSCA_ALINH_CHECK_EN
    confere("alinh_pc", pc, 32'h100);
    confere("alinh_err", 32'(erroAlinh), 32'd1);
    ciclo(0, 0, 0, 1, 0, 32'h200, 0);
    confere("alinh_hold", 32'(erroAlinh), 32'd1);
`else
    confere("alinh_pc", pc, 32'h102);
    confere("alinh_err", 32'(erroAlinh), 32'd0);
`endif

    for (int i = 0; i < 2000; i++) begin
      ciclo(($urandom_range(99) == 0),
            ($urandom_range(2) == 0),
            ($urandom_range(3) == 0),
            ($urandom_range(3) == 0),
            1'($urandom),
            ($urandom_range(1) == 0)
              ? ($urandom & ~32'd3) : $urandom,
            $urandom);
    end

    $display("%0d/%0d checks passed", passou, total);
    $finish;
  end

endmodule

// File: doc/busca_instrucao.md
# busca_instrucao

Instruction-fetch datapath stage driven by the multicycle control unit. Consumes the control strobes `escreveInstr`, `escritaPC`, `estadoUla` and `RWmemoria`. Holds the PC, issues a fixed-latency instruction-memory read, loads the instruction register and presents decoded RISC-V fields to the downstream decode/register-file stage.

## Interface
- `PC_W`, 32: PC and memory address width.
- `INSTR_W`, 32: instruction width.
- `MEM_LAT`, 2: cycles from read request to valid `memDado`; legal range 1..15.
- `RESET_PC`, 0: PC value after reset.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: reset, synchronous and active-high despite the name.
- `escreveInstr` in 1: fetch request strobe from the control unit.
- `RWmemoria` in 1: 0 = read; a fetch request with 1 is ignored.
- `escritaPC` in 1: PC write enable.
- `estadoUla` in 1: when `escritaPC`=1, 1 selects PC+4 and 0 selects `pcAlvo`.
- `pcAlvo` in PC_W: branch/jump target.
- `memDado` in INSTR_W: instruction memory read data.
- `memAddr` out PC_W: latched fetch address.
- `memLer` out 1: memory read enable.
- `pc` out PC_W: current PC.
- `instr` out INSTR_W: instruction register.
- `opcode` out 7, `rd` out 5, `funct3` out 3, `rs1` out 5, `rs2` out 5, `funct7` out 7: combinational slices of `instr`.
- `instrValida` out 1: one-cycle pulse when `instr` is updated.
- `ocupado` out 1: a fetch is in flight.
- `erroAlinh` out 1: sticky misaligned-target flag (see Configuration).

## Operation
- FSM states:
  - OCIOSO: `escreveInstr`=1 and `RWmemoria`=0 → latch `memAddr`=`pc`, load the wait counter with MEM_LAT, go to ESPERA.
  - ESPERA: counter decrements each cycle. When the counter reaches 1, `instr`<=`memDado` that edge and go to ENTREGA.
  - ENTREGA: `instrValida`=1 for this cycle only; go to OCIOSO unconditionally.
- `memLer`=1 exactly while in ESPERA. `ocupado`=1 in ESPERA and ENTREGA.
- `escreveInstr` in ESPERA or ENTREGA is dropped; no queueing.
- PC update is independent of the FSM and allowed in any state:
  - `escritaPC`=1, `estadoUla`=1 → `pc`<=`pc`+4, wrapping modulo 2^PC_W.
  - `escritaPC`=1, `estadoUla`=0 → `pc`<=`pcAlvo`.
- A PC change during ESPERA does not alter `memAddr`; the in-flight fetch completes at the old address.
- Same-cycle `escreveInstr` and `escritaPC` in OCIOSO: the fetch latches the pre-update `pc`.
- Reset values:
  - `pc`=RESET_PC, `instr`=0 (so all decoded fields are 0).
  - `memAddr`=0, `memLer`=0, `instrValida`=0, `ocupado`=0, `erroAlinh`=0.
  - FSM in OCIOSO.
- Reset in any state aborts the fetch. Data arriving afterwards is never captured.

## Timing
- Request accepted at edge t → `memLer` high in cycles t+1..t+MEM_LAT.
- `memDado` is sampled at the edge ending cycle t+MEM_LAT.
- `instr` is valid and `instrValida`=1 in cycle t+MEM_LAT+1.
- Fetch-to-fetch minimum spacing: MEM_LAT+2 cycles. Next request is accepted at the edge ending ENTREGA's successor cycle in OCIOSO.
- PC update is visible in the cycle after the `escritaPC` edge.

## Configuration
- `BUSCA_ALINH_CHECK_EN` defined:
  - A `pcAlvo` load with bits [1:0]≠0 sets `erroAlinh` (sticky until reset).
  - The loaded PC has bits [1:0] forced to 0.
- Undefined:
  - `pcAlvo` is loaded unmodified.
  - `erroAlinh` is tied to 0.
  - No check logic is synthesized.

## Structure
- Package `busca_pkg` holds:
  - the FSM enum (OCIOSO, ESPERA, ENTREGA);
  - `PC_INC`=4;
  - field bit positions: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25].
- Sub-module `contador_espera`: loadable 4-bit down-counter with a `fim` output (count==1), instantiated once.

## Test plan
- Reset, MEM_LAT=2, RESET_PC=0: pulse `escreveInstr` at t, `memDado`=0x00A00093 → `memLer` high t+1..t+2, `memAddr`=0; at t+3 `instr`=0x00A00093, `opcode`=0x13, `rd`=1, `rs1`=0, `instrValida` pulse.
- Control-unit sequence (leMem, then addPC with `estadoUla`=1, then espera), repeated ×3 → fetch addresses 0, 4, 8; `pc`=12 at end.
- `escritaPC`=1, `estadoUla`=0, `pcAlvo`=0x100 during ESPERA → in-flight `memAddr` stays 0; next fetch uses 0x100.
- `escreveInstr` with `RWmemoria`=1 → no `memLer`, `instr` unchanged. Second `escreveInstr` during ESPERA → ignored, only one `instrValida`.
- `rst_n`=1 mid-ESPERA → next cycle `memLer`=0, `pc`=RESET_PC, `instr`=0, no `instrValida`. `pc`=0xFFFFFFFC plus PC+4 → 0.
- With `BUSCA_ALINH_CHECK_EN`: `pcAlvo`=0x102 → `pc`=0x100, `erroAlinh`=1, flag held until reset. Without the macro: `pc`=0x102, `erroAlinh`=0.
